// File: rtl/isa_pkg.sv
// Shared fetch-stage definitions: FSM state type, default HALT encoding and PC width.
package isa_pkg;

  localparam int PC_W = 8;
  localparam logic [31:0] HALT_WORD = 32'h1800_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// First-word-fall-through FIFO holding fetched {instruction, pc} entries.
// Flush wins over push and pop; the caller only pushes when not full or popping.
module fetch_buffer #(
  parameter int Width = 40,
  parameter int Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(Depth);

  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [Width-1:0]   mem [Depth];
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= data_in;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instruction_fetch_controller.sv
// Owns the PC, steps through the combinational instruction memory and hands
// captured words to decode over valid/ready; supports redirect and self-halt.
module instruction_fetch_controller
  import isa_pkg::*;
#(
  parameter int                  byte_W    = 4,
  parameter int                  Addr_W    = isa_pkg::PC_W,
  parameter logic [Addr_W-1:0]   Reset_PC  = '0,
  parameter int                  Buf_Depth = 2,
  parameter logic [8*byte_W-1:0] HALT_WORD = isa_pkg::HALT_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [Addr_W-1:0]     redirect_target,
  output logic [Addr_W-1:0]     imem_address,
  input  logic [8*byte_W-1:0]   imem_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*byte_W-1:0]   out_instruction,
  output logic [Addr_W-1:0]     out_pc,
  output logic                  halted,
  output logic [15:0]           fetch_count,
  output fetch_state_t          fsm_state
);

  // Handshake: the head entry transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and a
  // redirect in the same cycle discards the head instead of transferring it.

  localparam int                ENTRY_W    = 8*byte_W + Addr_W;
  localparam logic [Addr_W-1:0] PC_STEP    = Addr_W'(byte_W);
  localparam logic [Addr_W-1:0] ALIGN_MASK = ~(Addr_W'(byte_W - 1));

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [Addr_W-1:0]  pc;
  logic               push;
  logic               pop;
  logic               buf_full;
  logic               buf_empty;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] last_entry;

  assign pop  = !buf_empty && out_ready && !redirect_valid;
  assign push = (state == FETCH) && fetch_enable && !redirect_valid && (!buf_full || pop);

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = fetch_enable ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_enable) state_next = FETCH;
        FETCH: begin
          if (!fetch_enable)                               state_next = IDLE;
          else if (push && imem_instruction == HALT_WORD)  state_next = HALT;
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= Reset_PC;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) pc <= redirect_target & ALIGN_MASK;
      else if (push)      pc <= pc + PC_STEP;
      if (push) fetch_count <= fetch_count + 16'd1;
    end
  end

  // Remembers the last presented head so outputs hold while the buffer is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last_entry <= '0;
    else if (!buf_empty) last_entry <= head_entry;
  end

  fetch_buffer #(
    .Width (ENTRY_W),
    .Depth (Buf_Depth)
  ) u_fetch_buffer (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .data_in ({imem_instruction, pc}),
    .head    (head_entry),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign {out_instruction, out_pc} = buf_empty ? last_entry : head_entry;
  assign out_valid    = !buf_empty;
  assign halted       = (state == HALT);
  assign imem_address = pc;
  assign fsm_state    = state;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Drives the fetch controller against a byte-array memory and a queue-based
// reference model; directed program scenarios followed by random traffic.
module tb_instruction_fetch_controller;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] HALT_W  = 32'h1800_0000;
  localparam int          M_IDLE  = 0;
  localparam int          M_FETCH = 1;
  localparam int          M_HALT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [7:0]  imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [7:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  fsm_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [256];
  logic [39:0] exp_q[$];
  logic [7:0]  m_pc;
  int          m_mode;
  logic [15:0] m_cnt;
  logic [39:0] m_last;

  always #5 clk = ~clk;

  instruction_fetch_controller dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_enable     (fetch_enable),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .halted           (halted),
    .fetch_count      (fetch_count),
    .fsm_state        (fsm_state)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  always_comb imem_instruction = mem_word(imem_address);

  task automatic write_word(input logic [7:0] a, input logic [31:0] w);
    mem[a]        = w[7:0];
    mem[a + 8'd1] = w[15:8];
    mem[a + 8'd2] = w[23:16];
    mem[a + 8'd3] = w[31:24];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic load_program();
    clear_mem();
    write_word(8'h00, 32'h0412_1000);
    write_word(8'h04, 32'h0412_3004);
    write_word(8'h08, 32'h0083_2101);
    write_word(8'h0C, HALT_W);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) m_last = exp_q[0];
    check("out_valid",       out_valid,       exp_q.size() > 0);
    check("out_instruction", out_instruction, m_last[39:8]);
    check("out_pc",          out_pc,          m_last[7:0]);
    check("halted",          halted,          m_mode == M_HALT);
    check("imem_address",    imem_address,    m_pc);
    check("fetch_count",     fetch_count,     m_cnt);
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    logic [31:0] w;
    bit          pop, push;
    if (redirect_valid) begin
      exp_q.delete();
      m_pc   = redirect_target & 8'hFC;
      m_mode = fetch_enable ? M_FETCH : M_IDLE;
    end else begin
      pop  = (exp_q.size() > 0) && out_ready;
      push = (m_mode == M_FETCH) && fetch_enable && (exp_q.size() < DEPTH || pop);
      w    = mem_word(m_pc);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({w, m_pc});
        m_pc  = m_pc + 8'd4;
        m_cnt = m_cnt + 16'd1;
      end
      if (m_mode == M_IDLE && fetch_enable)                 m_mode = M_FETCH;
      else if (m_mode == M_FETCH && !fetch_enable)          m_mode = M_IDLE;
      else if (m_mode == M_FETCH && push && w == HALT_W)    m_mode = M_HALT;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid",   out_valid,    1'b0);
    check("rst_halted",      halted,       1'b0);
    check("rst_imem_addr",   imem_address, 8'h00);
    check("rst_fetch_count", fetch_count,  16'h0000);
    fetch_enable    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'h00;
    out_ready       = 1'b0;
    exp_q.delete();
    m_pc   = 8'h00;
    m_mode = M_IDLE;
    m_cnt  = 16'h0000;
    m_last = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    reset           = 1'b1;
    fetch_enable    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'h00;
    out_ready       = 1'b0;
    clear_mem();
    @(negedge clk);

    // Straight-line program ending in HALT
    do_reset();
    load_program();
    fetch_enable = 1'b1;
    out_ready    = 1'b1;
    run(8);
    check("t1_fetch_count", fetch_count,  16'd4);
    check("t1_halted",      halted,       1'b1);
    check("t1_pc_held",     imem_address, 8'h10);

    // Redirect out of HALT resumes at the target
    redirect_valid  = 1'b1;
    redirect_target = 8'h04;
    cycle();
    check("t4_unhalted", halted, 1'b0);
    redirect_valid = 1'b0;
    run(6);

    // Backpressure: two entries buffered, PC parked at 8
    do_reset();
    fetch_enable = 1'b1;
    out_ready    = 1'b0;
    run(5);
    check("t2_addr_held", imem_address, 8'h08);
    out_ready = 1'b1;
    run(6);

    // Redirect to an unaligned target with a full buffer
    do_reset();
    fetch_enable = 1'b1;
    run(4);
    redirect_valid  = 1'b1;
    redirect_target = 8'h09;
    cycle();
    check("t3_flushed", out_valid,    1'b0);
    check("t3_aligned", imem_address, 8'h08);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    cycle();
    check("t3_first_pc",   out_pc,          8'h08);
    check("t3_first_word", out_instruction, 32'h0083_2101);
    run(4);

    // PC wrap at the top of the address space
    do_reset();
    clear_mem();
    fetch_enable    = 1'b1;
    out_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 8'hFC;
    cycle();
    redirect_valid = 1'b0;
    run(2);
    fetch_enable = 1'b0;
    cycle();
    check("t5_fetch_count", fetch_count, 16'd2);
    check("t5_wrapped_pc",  out_pc,      8'h00);

    // Asynchronous reset while the buffer is full
    do_reset();
    load_program();
    fetch_enable = 1'b1;
    run(4);
    #3;
    do_reset();

    // Random traffic over a random program sprinkled with HALT words
    for (int a = 0; a < 256; a += 4)
      write_word(8'(a), ($urandom_range(0, 7) == 0) ? HALT_W : $urandom);
    for (int i = 0; i < 600; i++) begin
      fetch_enable    = ($urandom_range(0, 9) != 0);
      out_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_target = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
